a2d_with_pots: RTL and testbench



---
 rtl/a2d_pkg.sv | 19 +
 rtl/a2d_spi_slave.sv | 68 ++++++
 rtl/a2d_with_pots.sv | 68 ++++++
 tb/tb_a2d_with_pots.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants for the pot-backed SPI A/D converter model.
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int CH_BITS    = 3;
  localparam int CMD_CH_LSB = 11;
  localparam int CMD_CH_MSB = 13;

  localparam logic [CH_BITS-1:0] CH_B1  = 3'd0;
  localparam logic [CH_BITS-1:0] CH_LP  = 3'd1;
  localparam logic [CH_BITS-1:0] CH_B3  = 3'd2;
  localparam logic [CH_BITS-1:0] CH_HP  = 3'd3;
  localparam logic [CH_BITS-1:0] CH_B2  = 3'd4;
  localparam logic [CH_BITS-1:0] CH_VOL = 3'd7;

  localparam logic [4:0] CNT_FULL = 5'd16;

endpackage

// File: rtl/a2d_spi_slave.sv
// SPI mode-0 slave front end: pin synchronizers, edge detection, shifters
// and a saturating bit counter. Frame content is decided by the parent.
module a2d_spi_slave
  import a2d_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  tx_load_i,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  output logic                  miso_o,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic [FRAME_BITS-1:0] rx_cmd_o
);

  logic [2:0]            ss_q;
  logic [2:0]            sclk_q;
  logic [2:0]            mosi_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [FRAME_BITS-1:0] rx_q;
  logic [4:0]            cnt_q;

  logic ss_fall, ss_rise, ss_low, sclk_rise, sclk_fall;

  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign ss_low    = ~ss_q[2];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 3'b000;
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n_i};
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[1:0], mosi_i};

      if (tx_load_i) begin
        tx_q <= tx_data_i;
      end else if (ss_low && !ss_rise && sclk_fall && cnt_q != 5'd0) begin
        tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
      end

      // A slave-select rise in the same clk as an SCLK edge wins; the edge is dropped.
      if (ss_fall) begin
        cnt_q <= '0;
      end else if (ss_low && !ss_rise && sclk_rise) begin
        rx_q <= {rx_q[FRAME_BITS-2:0], mosi_q[2]};
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign miso_o        = tx_q[FRAME_BITS-1] & ~ss_q[2];
  assign frame_start_o = ss_fall;
  assign frame_done_o  = ss_rise & (cnt_q == CNT_FULL);
  assign rx_cmd_o      = rx_q;

endmodule

// File: rtl/a2d_with_pots.sv
// 8-channel 12-bit SPI A/D model fed by six slide pots; each frame returns
// the channel commanded by the previous complete frame.
module a2d_with_pots
  import a2d_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 SCLK,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [DATA_BITS-1:0] LP,
  input  logic [DATA_BITS-1:0] B1,
  input  logic [DATA_BITS-1:0] B2,
  input  logic [DATA_BITS-1:0] B3,
  input  logic [DATA_BITS-1:0] HP,
  input  logic [DATA_BITS-1:0] VOL
);

  logic                  frame_start;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] rx_cmd;
  logic [FRAME_BITS-1:0] tx_data;
  logic [DATA_BITS-1:0]  pot_sel;
  logic [CH_BITS-1:0]    ch_prev_q;
  logic                  unused_cmd_bits;

  a2d_spi_slave u_spi (
    .clk           (clk),
    .rst           (rst),
    .ss_n_i        (SS_n),
    .sclk_i        (SCLK),
    .mosi_i        (MOSI),
    .tx_load_i     (frame_start),
    .tx_data_i     (tx_data),
    .miso_o        (MISO),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .rx_cmd_o      (rx_cmd)
  );

  // Aborted frames never raise frame_done, so the pipelined channel survives them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_prev_q <= CH_B1;
    end else if (frame_done) begin
      ch_prev_q <= rx_cmd[CMD_CH_MSB:CMD_CH_LSB];
    end
  end

  always_comb begin
    pot_sel = '0;
    case (ch_prev_q)
      CH_B1:   pot_sel = B1;
      CH_LP:   pot_sel = LP;
      CH_B3:   pot_sel = B3;
      CH_HP:   pot_sel = HP;
      CH_B2:   pot_sel = B2;
      CH_VOL:  pot_sel = VOL;
      default: pot_sel = '0;
    endcase
  end

  assign tx_data = {{(FRAME_BITS-DATA_BITS){1'b0}}, pot_sel};

  assign unused_cmd_bits = ^{rx_cmd[FRAME_BITS-1:CMD_CH_MSB+1], rx_cmd[CMD_CH_LSB-1:0]};

endmodule

// File: tb/tb_a2d_with_pots.sv
// Directed bench for a2d_with_pots: a simple SPI master drives frames and
// compares returned words against hand-computed values.
module tb_a2d_with_pots;

  logic        clk;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] LP, B1, B2, B3, HP, VOL;

  int n_checks;
  int n_fail;

  a2d_with_pots dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO),
    .LP   (LP),
    .B1   (B1),
    .B2   (B2),
    .B3   (B3),
    .HP   (HP),
    .VOL  (VOL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One SPI frame of nbits, phases of 'half' clk; MISO sampled twice before each rise.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int half,
                           input bit chg_lp, input logic [11:0] new_lp,
                           output logic [15:0] rd, output bit stable);
    logic a, b;
    rd = '0;
    stable = 1'b1;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    if (chg_lp) LP = new_lp;
    for (int i = 0; i < nbits; i++) begin
      MOSI = cmd[15-i];
      repeat (half-1) @(negedge clk);
      a = MISO;
      @(negedge clk);
      b = MISO;
      if (a !== b) stable = 1'b0;
      rd = {rd[14:0], b};
      SCLK = 1'b1;
      repeat (half) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    B1 = 12'hABC; LP = 12'h123; B2 = 12'h000; B3 = 12'h000; HP = 12'h000; VOL = 12'h000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (MISO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_miso: got %b expected 0", MISO);
    end
  endtask

  task automatic test_basic;
    logic [15:0] rd;
    bit st;
    spi_frame(16'h0800, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0ABC) begin
      n_fail++;
      $display("FAIL basic_first_b1: got %h expected 0abc", rd);
    end
    spi_frame(16'h0800, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0123) begin
      n_fail++;
      $display("FAIL basic_second_lp: got %h expected 0123", rd);
    end
  endtask

  task automatic test_sweep;
    logic [2:0]  chs [9];
    logic [15:0] exp_v [9];
    logic [15:0] rd;
    bit st;
    B1 = 12'h111; LP = 12'h222; B3 = 12'h333; HP = 12'h444; B2 = 12'h555; VOL = 12'h777;
    chs   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd6, 3'd3};
    exp_v = '{16'h0222, 16'h0111, 16'h0222, 16'h0333, 16'h0444,
              16'h0555, 16'h0777, 16'h0000, 16'h0000};
    for (int k = 0; k < 9; k++) begin
      spi_frame({2'b00, chs[k], 11'h000}, 16, 4, 1'b0, 12'h000, rd, st);
      n_checks++;
      if (rd !== exp_v[k]) begin
        n_fail++;
        $display("FAIL sweep_frame%0d_ch%0d: got %h expected %h", k, chs[k], rd, exp_v[k]);
      end
    end
  endtask

  task automatic test_abort;
    logic [15:0] rd;
    bit st;
    spi_frame(16'h3800, 8, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0004) begin
      n_fail++;
      $display("FAIL abort_partial_bits: got %h expected 0004", rd);
    end
    spi_frame(16'h0800, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0444) begin
      n_fail++;
      $display("FAIL abort_keeps_hp: got %h expected 0444", rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd;
    bit st;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      MOSI = 1'b0;
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (MISO !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_miso: got %b expected 1", MISO);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (MISO !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_miso_cleared: got %b expected 0", MISO);
    end
    repeat (6) @(negedge clk);
    SS_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_frame(16'h0800, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0111) begin
      n_fail++;
      $display("FAIL midrst_next_b1: got %h expected 0111", rd);
    end
    spi_frame(16'h0800, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0222) begin
      n_fail++;
      $display("FAIL midrst_then_lp: got %h expected 0222", rd);
    end
  endtask

  task automatic test_pot_change;
    logic [15:0] rd;
    bit st;
    spi_frame(16'h0800, 16, 4, 1'b1, 12'hFFF, rd, st);
    n_checks++;
    if (rd !== 16'h0222) begin
      n_fail++;
      $display("FAIL potchg_old_word: got %h expected 0222", rd);
    end
    spi_frame(16'h0800, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0FFF) begin
      n_fail++;
      $display("FAIL potchg_new_word: got %h expected 0fff", rd);
    end
  endtask

  task automatic test_min_phase;
    logic [15:0] rd;
    bit st;
    spi_frame(16'hD7FF, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0FFF) begin
      n_fail++;
      $display("FAIL minphase_word: got %h expected 0fff", rd);
    end
    n_checks++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL minphase_stable_a: got %b expected 1", st);
    end
    spi_frame(16'h0000, 16, 4, 1'b0, 12'h000, rd, st);
    n_checks++;
    if (rd !== 16'h0333) begin
      n_fail++;
      $display("FAIL minphase_junk_bits_cmd: got %h expected 0333", rd);
    end
    n_checks++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL minphase_stable_b: got %b expected 1", st);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    LP = '0; B1 = '0; B2 = '0; B3 = '0; HP = '0; VOL = '0;
    test_reset();
    test_basic();
    test_sweep();
    test_abort();
    test_reset_mid();
    test_pot_change();
    test_min_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
